// File: rtl/util_fifo_fwft.sv
// Synchronous single-clock FIFO with all DEPTH entries usable, selectable FWFT read mode, status flags and flush.
// Latency: standard mode dout/valid 1 cycle after rd_en; FWFT mode head word visible 1 cycle after its write edge.
// Backpressure: writes are refused when full unless a read fires in the same cycle; refused writes or reads on empty pulse overflow/underflow.
//
// Ports:
//   clk          - clock, all logic on the rising edge
//   rst_n        - asynchronous reset, ACTIVE-HIGH despite the name
//   clr          - synchronous flush; overrides wr_en/rd_en in the same cycle
//   wr_en, din   - write request and data
//   rd_en        - read request (FWFT: acknowledge of the head word)
//   dout, valid  - read data; valid is a 1-cycle pulse (standard) or a level (FWFT)
//   full, empty, almost_full, almost_empty, count - occupancy status from the registered pointers
//   overflow, underflow - registered 1-cycle pulses, one cycle after the offending request
module util_fifo_fwft #(
    parameter int BITLEN    = 64,
    parameter int DEPTH_BIT = 3,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = (1 << DEPTH_BIT) - 2,
    parameter int AEMPTY_TH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [BITLEN-1:0] din,
    input  logic              rd_en,
    output logic [BITLEN-1:0] dout,
    output logic              valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [DEPTH_BIT:0] count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << DEPTH_BIT;
    localparam logic [DEPTH_BIT:0] AF_TH   = AFULL_TH[DEPTH_BIT:0];
    localparam logic [DEPTH_BIT:0] AE_TH   = AEMPTY_TH[DEPTH_BIT:0];
    localparam logic [DEPTH_BIT:0] PTR_ONE = {{DEPTH_BIT{1'b0}}, 1'b1};

    logic [BITLEN-1:0]    r_mem [DEPTH];
    logic [DEPTH_BIT:0]   r_wr_ptr;
    logic [DEPTH_BIT:0]   r_rd_ptr;
    logic                 r_overflow;
    logic                 r_underflow;

    logic [DEPTH_BIT-1:0] w_wr_idx;
    logic [DEPTH_BIT-1:0] w_rd_idx;
    logic [DEPTH_BIT:0]   w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_rd_fire;
    logic                 w_wr_fire;

    assign w_wr_idx = r_wr_ptr[DEPTH_BIT-1:0];
    assign w_rd_idx = r_rd_ptr[DEPTH_BIT-1:0];

    // The extra MSB on each pointer distinguishes full from empty, so
    // every entry is usable and the difference is the exact occupancy.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[DEPTH_BIT] != r_rd_ptr[DEPTH_BIT]) &&
                     (w_wr_idx == w_rd_idx);

    assign w_rd_fire = rd_en && !w_empty;
    // A full FIFO may still take a write when the head leaves in the same cycle.
    assign w_wr_fire = wr_en && (!w_full || w_rd_fire);

    // Storage has no reset; entries are only observed after being written.
    always_ff @(posedge clk) begin
        if (w_wr_fire && !clr) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_overflow  <= wr_en && !w_wr_fire;
            r_underflow <= rd_en && w_empty;
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [BITLEN-1:0] r_dout;
            logic              r_valid;

            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    r_dout  <= '0;
                    r_valid <= 1'b0;
                end else if (clr) begin
                    r_dout  <= '0;
                    r_valid <= 1'b0;
                end else if (w_rd_fire) begin
                    r_dout  <= r_mem[w_rd_idx];
                    r_valid <= 1'b1;
                end else begin
                    r_valid <= 1'b0;
                end
            end

            assign dout  = r_dout;
            assign valid = r_valid;
        end else begin : g_fwft
            // Head word is presented straight from storage; masked to zero
            // while empty so the unwritten array never leaks onto dout.
            assign dout  = w_empty ? '0 : r_mem[w_rd_idx];
            assign valid = !w_empty;
        end
    endgenerate

    assign count        = w_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (w_count >= AF_TH);
    assign almost_empty = (w_count <= AE_TH);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: doc/util_fifo_fwft.md
Name: util_fifo_fwft

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the platform's utility FIFO.
- Adds all-entries-usable depth, a selectable first-word-fall-through (FWFT) read mode, an occupancy count, almost-full/almost-empty thresholds, overflow/underflow pulses and a synchronous flush.
- Sits between AXI/DMA data movers and compute pipelines wherever rate decoupling or elastic buffering is needed.

Parameters:
- BITLEN, 64: data word width in bits.
- DEPTH_BIT, 3: log2 of depth; DEPTH = 2**DEPTH_BIT entries, all usable.
- FWFT, 0: 0 = standard mode (registered dout, 1-cycle read latency); 1 = first-word-fall-through.
- AFULL_TH, DEPTH-2: almost_full asserted when count >= AFULL_TH.
- AEMPTY_TH, 1: almost_empty asserted when count <= AEMPTY_TH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-high (asserted = 1) despite the name.
- clr  in  1  synchronous flush; empties the FIFO.
- wr_en  in  1  write request.
- din  in  BITLEN  write data.
- rd_en  in  1  read request (FWFT mode: acknowledge of the head word).
- dout  out  BITLEN  read data.
- valid  out  1  dout holds a valid word (standard: 1-cycle pulse; FWFT: level).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  DEPTH_BIT+1  current occupancy, 0..DEPTH.
- overflow  out  1  1-cycle pulse: write requested but not accepted.
- underflow  out  1  1-cycle pulse: read requested but FIFO empty.

Behaviour:
- Pointers are DEPTH_BIT+1 bits (wrap bit as MSB).
- count = wr_ptr - rd_ptr, modulo 2**(DEPTH_BIT+1).
- full: MSBs differ, lower bits equal. empty: pointers equal.
- Storage array is not reset; contents are undefined until written.
- Reset (rst_n=1, async): pointers, count, dout, valid, overflow and underflow go to 0. empty=1, almost_empty=1, full=0, almost_full=0. Reset mid-transfer discards all data. First accepted write is on the first rising edge after rst_n deasserts.
- rd_fire = rd_en && !empty.
- wr_fire = wr_en && (!full || rd_fire). Writing while full is allowed only when a read fires in the same cycle; count is then unchanged.
- Write and read on empty: the write is accepted, the read is not, underflow pulses, count becomes 1.
- On wr_fire: mem[wr_ptr[DEPTH_BIT-1:0]] <= din; wr_ptr increments. On rd_fire: rd_ptr increments. Pointer wrap is natural modulo arithmetic.
- overflow <= wr_en && !wr_fire. underflow <= rd_en && empty. Both are registered, 1-cycle pulses, one cycle after the offending request.
- Standard mode (FWFT=0): on rd_fire, dout <= mem[rd_ptr] and valid <= 1 on the next edge; otherwise valid <= 0 and dout holds its value.
- FWFT mode (FWFT=1): dout = mem[rd_ptr] combinationally and valid = !empty. A word written into an empty FIFO appears on dout one cycle after the write edge. rd_en consumes the head word; the next word is presented in the same cycle the pointer advances.
- Status flags and count are derived from the registered pointers and update one edge after a fire.
- clr: on the next edge, pointers go to 0, valid <= 0, dout <= 0. clr overrides wr_en/rd_en in the same cycle (no write stored), and no overflow/underflow pulse is raised.

Test Plan:
- Reset then idle: assert rst_n for 3 cycles, release -> empty=1, almost_empty=1, count=0, full=0, dout=0, valid=0.
- Fill/drain, FWFT=0, DEPTH_BIT=3: write 0x10..0x17 on 8 consecutive cycles -> full=1, count=8, almost_full=1 from count=6. A 9th write -> overflow pulse, count stays 8. Read 8 words -> dout 0x10..0x17, each 1 cycle after its rd_en with valid=1; then empty=1. A further rd_en -> underflow pulse.
- Wrap-around: 20 cycles of interleaved write/read bursts (3 writes, 2 reads) -> data order preserved across pointer wrap, count tracks the exact difference, no spurious full or empty.
- Simultaneous R/W: with the FIFO full, assert wr_en=rd_en=1 with din=0xAA for 4 cycles -> no overflow, count stays 8, 0xAA words appear after the original 8. With the FIFO empty, wr_en=rd_en=1 -> underflow pulse, count=1.
- FWFT=1: write 0x55 into empty -> next cycle dout=0x55, valid=1 with no rd_en. Pulse rd_en once -> valid=0, empty=1 the next cycle.
- clr and async reset mid-operation: with count=5, assert clr together with wr_en -> next cycle count=0, empty=1, no overflow. Refill to 3, then assert rst_n between clock edges -> outputs reach reset values immediately, without waiting for a clock edge.
